// File: rtl/multicycle_control.sv
// Main controller for a multicycle RV32 datapath. The FSM state is registered and the
// datapath controls are decoded from it.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t cur;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= S_FETCH;
      instr_count <= '0;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: cur <= S_MEMADR;
            OP_RTYPE:          cur <= S_EXECR;
            OP_ITYPE:          cur <= S_EXECI;
            OP_BRANCH:         cur <= S_BRANCH;
            OP_JAL:            cur <= S_JAL;
            OP_LUI:            cur <= S_LUI;
            default:           cur <= S_TRAP;
          endcase
        end
        // The IR is held stable here, so anything other than a load or a store is a corrupted decode.
        S_MEMADR: begin
          if (opcode == OP_LOAD)       cur <= S_MEMREAD;
          else if (opcode == OP_STORE) cur <= S_MEMWRITE;
          else                         cur <= S_TRAP;
        end
        S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWB: begin
          cur         <= S_FETCH;
          instr_count <= instr_count + 32'd1;
        end
        S_MEMWRITE: begin
          if (mem_ready) begin
            cur         <= S_FETCH;
            instr_count <= instr_count + 32'd1;
          end
        end
        S_EXECR, S_EXECI, S_JAL, S_LUI: cur <= S_ALUWB;
        S_ALUWB, S_BRANCH: begin
          cur         <= S_FETCH;
          instr_count <= instr_count + 32'd1;
        end
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_TRAP;
      endcase
    end
  end

  assign state = cur;

  // NOTE: every output gets a default before the case, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ALUOp      = 2'b00;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        ALUOp     = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALUOp     = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        ALUOp     = 2'b01;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_b = 2'b01;
        ALUOp     = 2'b11;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // While reset is asserted, the datapath must see no enables. This includes the fetch read.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: it walks each instruction class, the trap path and
// mid-instruction reset, and compares against hand-computed expected values.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, adr_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src, ALUOp;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .ALUOp      (ALUOp),
    .state      (state),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1ns after the edge, away from the sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = 7'b0000000; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick(); settle();
    check("rst_state",     state, 0);
    check("rst_count",     instr_count, 0);
    check("rst_illegal",   illegal, 0);
    check("rst_pc_write",  pc_write, 0);
    check("rst_ir_write",  ir_write, 0);
    check("rst_reg_write", reg_write, 0);
    rst = 1'b0; mem_ready = 1'b0; opcode = 7'b0110011;
    settle();

    // R-type, including one fetch stall.
    check("fetch_stall_ir", ir_write, 0);
    tick(); settle();
    check("fetch_hold_state", state, 0);
    mem_ready = 1'b1; settle();
    check("r_fetch_ir",    ir_write, 1);
    check("r_fetch_pc",    pc_write, 1);
    check("r_fetch_rd",    mem_read, 1);
    check("r_fetch_srcb",  alu_src_b, 2'b10);
    check("r_fetch_res",   result_src, 2'b10);
    check("r_fetch_rw",    reg_write, 0);
    tick(); settle();
    check("r_decode_state", state, 1);
    check("r_decode_srca",  alu_src_a, 2'b01);
    check("r_decode_srcb",  alu_src_b, 2'b01);
    check("r_decode_rw",    reg_write, 0);
    tick(); settle();
    check("r_execr_state", state, 6);
    check("r_execr_aluop", ALUOp, 2'b10);
    check("r_execr_srca",  alu_src_a, 2'b10);
    check("r_execr_srcb",  alu_src_b, 2'b00);
    check("r_execr_rw",    reg_write, 0);
    tick(); settle();
    check("r_aluwb_state", state, 8);
    check("r_aluwb_rw",    reg_write, 1);
    check("r_aluwb_res",   result_src, 2'b00);
    tick(); settle();
    check("r_done_state", state, 0);
    check("r_done_count", instr_count, 1);

    // Load, with a three-cycle memory stall in MEMREAD.
    opcode = 7'b0000011;
    tick(); settle();
    check("ld_decode_state", state, 1);
    tick(); settle();
    check("ld_memadr_state", state, 2);
    check("ld_memadr_srca",  alu_src_a, 2'b10);
    mem_ready = 1'b0;
    tick(); settle();
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_state", state, 3);
      check("ld_wait_rd",    mem_read, 1);
      check("ld_wait_adr",   adr_src, 1);
      tick(); settle();
    end
    mem_ready = 1'b1; settle();
    check("ld_ready_state", state, 3);
    tick(); settle();
    check("ld_memwb_state", state, 4);
    check("ld_memwb_rw",    reg_write, 1);
    check("ld_memwb_res",   result_src, 2'b01);
    mem_ready = 1'b0;
    tick(); settle();
    check("ld_done_state", state, 0);
    check("ld_done_count", instr_count, 2);

    // beq taken, then beq not taken.
    opcode = 7'b1100011; mem_ready = 1'b1;
    tick(); tick(); zero = 1'b1; settle();
    check("beq1_state", state, 9);
    check("beq1_pcw",   pc_write, 1);
    check("beq1_aluop", ALUOp, 2'b01);
    tick(); settle();
    check("beq1_done_state", state, 0);
    check("beq1_done_count", instr_count, 3);
    tick(); tick(); zero = 1'b0; settle();
    check("beq0_state", state, 9);
    check("beq0_pcw",   pc_write, 0);
    tick(); settle();
    check("beq0_done_state", state, 0);
    check("beq0_done_count", instr_count, 4);

    // JAL: ALUOp never becomes 11 on this path.
    opcode = 7'b1101111;
    check("jal_fetch_aluop", ALUOp, 2'b00);
    tick(); settle();
    check("jal_decode_aluop", ALUOp, 2'b00);
    tick(); settle();
    check("jal_state", state, 10);
    check("jal_pcw",   pc_write, 1);
    check("jal_aluop", ALUOp, 2'b00);
    check("jal_srcb",  alu_src_b, 2'b10);
    tick(); settle();
    check("jal_aluwb_state", state, 8);
    check("jal_aluwb_aluop", ALUOp, 2'b00);
    tick(); settle();
    check("jal_done_state", state, 0);
    check("jal_done_count", instr_count, 5);

    // LUI
    opcode = 7'b0110111;
    tick(); tick(); settle();
    check("lui_state", state, 11);
    check("lui_aluop", ALUOp, 2'b11);
    check("lui_srcb",  alu_src_b, 2'b01);
    tick(); tick(); settle();
    check("lui_done_count", instr_count, 6);

    // Store that completes.
    opcode = 7'b0100011;
    tick(); tick(); mem_ready = 1'b0;
    tick(); settle();
    check("st_state", state, 5);
    check("st_wr",    mem_write, 1);
    check("st_adr",   adr_src, 1);
    mem_ready = 1'b1;
    tick(); settle();
    check("st_done_state", state, 0);
    check("st_done_count", instr_count, 7);

    // Store aborted by reset while it waits on memory.
    tick(); tick(); mem_ready = 1'b0;
    tick(); tick(); settle();
    check("st2_wait_state", state, 5);
    rst = 1'b1; mem_ready = 1'b1; settle();
    check("st2_rst_wr",    mem_write, 0);
    check("st2_rst_state", state, 0);
    check("st2_rst_count", instr_count, 0);
    check("st2_rst_pcw",   pc_write, 0);
    tick(); rst = 1'b0; mem_ready = 1'b0; settle();
    tick(); settle();
    check("st2_resume_state", state, 0);

    // Illegal opcode enters TRAP and stays there until reset.
    opcode = 7'b1111111; mem_ready = 1'b1;
    tick(); tick(); settle();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0]; settle();
      check("trap_state",   state, 12);
      check("trap_illegal", illegal, 1);
      check("trap_rd",      mem_read, 0);
      tick();
    end
    rst = 1'b1; settle();
    check("trap_rst_state",   state, 0);
    check("trap_rst_illegal", illegal, 0);
    tick(); rst = 1'b0; settle();
    check("trap_after_state", state, 0);
    check("trap_after_count", instr_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port opcode, input, 7, opcode field of the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag, valid in the same cycle.
REQ-005 SHALL have port mem_ready, input, 1, memory completes the current read/write this cycle.
REQ-006 SHALL have ports pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, outputs, 1 each, datapath enables/selects.
REQ-007 SHALL have ports alu_src_a, alu_src_b, result_src, ALUOp, outputs, 2 each; ALUOp encoding: 00 add, 01 sub, 10 funct-decoded, 11 LUI.
REQ-008 SHALL have port state, output, 4, current FSM state code.
REQ-009 SHALL have port illegal, output, 1, high while in TRAP.
REQ-010 SHALL have port instr_count, output, 32, retired-instruction counter.

Function
REQ-011 SHALL implement the state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-012 SHALL drive outputs as a Moore decode of state, except pc_write and ir_write in FETCH and pc_write in BRANCH; any output not listed for a state SHALL be 0.
REQ-013 FETCH SHALL drive adr_src=0, mem_read=1, alu_src_a=00 (PC), alu_src_b=10 (const 4), ALUOp=00, and result_src=10 (ALU direct); ir_write=pc_write=mem_ready; it SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE SHALL drive alu_src_a=01 (old PC), alu_src_b=01 (imm), and ALUOp=00 for the branch target.
REQ-015 DECODE SHALL dispatch on opcode: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL, 0110111 to LUI, and any other opcode to TRAP.
REQ-016 MEMADR SHALL drive alu_src_a=10 (rs1), alu_src_b=01, and ALUOp=00; it SHALL go to MEMREAD on a load opcode and to MEMWRITE on a store opcode.
REQ-017 MEMREAD SHALL drive adr_src=1, mem_read=1, and result_src=00; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB SHALL drive result_src=01 (memory data) and reg_write=1, then go to FETCH.
REQ-019 MEMWRITE SHALL drive adr_src=1, mem_write=1, and result_src=00; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXECR SHALL drive alu_src_a=10, alu_src_b=00 (rs2), and ALUOp=10; EXECI SHALL drive alu_src_a=10, alu_src_b=01, and ALUOp=10; both SHALL go to ALUWB.
REQ-021 ALUWB SHALL drive result_src=00 (ALU result register) and reg_write=1, then go to FETCH.
REQ-022 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, and pc_write=zero, then go to FETCH.
REQ-023 JAL SHALL drive alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, and pc_write=1, then go to ALUWB.
REQ-024 LUI SHALL drive alu_src_b=01 and ALUOp=11, then go to ALUWB.
REQ-025 TRAP SHALL drive illegal=1 with all enables at 0, and SHALL remain in TRAP until rst.
REQ-026 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE (with mem_ready=1), ALUWB, or BRANCH; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 mem_ready SHALL be ignored in every state except FETCH, MEMREAD, and MEMWRITE.

Reset
REQ-028 While rst=1, state SHALL be FETCH, instr_count SHALL be 0, and illegal SHALL be 0; pc_write, ir_write, and reg_write SHALL be forced to 0.
REQ-029 rst asserted mid-instruction, including during a mem_ready wait, SHALL abort immediately with no further enables; after rst is released, operation SHALL resume in FETCH.

Verification
REQ-030 Bench SHALL cover: R-type opcode 0110011 with mem_ready=1 -> states 0,1,6,8,0; reg_write=1 only in ALUWB; instr_count=1.
REQ-031 Bench SHALL cover: load 0000011 with mem_ready held 0 for 3 cycles in MEMREAD -> state stays 3 for 3 cycles; mem_read=1 throughout; MEMWB is reached one cycle after mem_ready=1.
REQ-032 Bench SHALL cover: beq 1100011 with zero=1, then with zero=0 -> pc_write=1 in BRANCH, then pc_write=0; both runs return to FETCH and count +1.
REQ-033 Bench SHALL cover: opcode 1111111 -> TRAP (state=12), illegal=1, held for 10 cycles; after rst, state=0 and illegal=0.
REQ-034 Bench SHALL cover: rst pulsed while in MEMWRITE waiting on mem_ready -> mem_write=0 immediately; state=0; instr_count=0.
REQ-035 Bench SHALL cover: JAL 1101111 -> states 0,1,10,8,0; pc_write=1 in JAL; ALUOp=11 never appears; LUI 0110111 shows ALUOp=11 in state 11.
